// File: rtl/irrigation_scheduler_pkg.sv
// Purpose: shared state encodings and water_level codes for the irrigation controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irrigation_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SPRINKLE = 3'd1,
      ST_DRIP     = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   localparam logic [2:0] WL_CRITICAL = 3'b000;
   localparam logic [2:0] WL_LOW      = 3'b001;
   localparam logic [2:0] WL_MID      = 3'b011;
   localparam logic [2:0] WL_HIGH     = 3'b111;

   // Only monotone thermometer codes are physically possible from the float chain.
   function automatic logic wl_legal(input logic [2:0] wl);
      return (wl == WL_CRITICAL) || (wl == WL_LOW) || (wl == WL_MID) || (wl == WL_HIGH);
   endfunction

endpackage

// File: rtl/irrigation_scheduler_tick_timer.sv
// Purpose: saturating tick counter with synchronous clear and count enable.
// Latency: count updates one edge after clr/en.
// Backpressure: none; clear wins over enable, count holds at all-ones.
module tick_timer #(
   parameter int WIDTH = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] TERMINAL = '1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != TERMINAL)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/irrigation_scheduler.sv
// Purpose: timed sprinkler/drip FSM with cooldown, fault lockout and supply refill hysteresis.
// Latency: all outputs registered, one edge after an input change.
// Backpressure: none; sensors sampled every cycle, timers advance only on tick.
module irrigation_scheduler
   import irrigation_scheduler_pkg::*;
#(
   parameter int MIN_ON_TICKS   = 4,
   parameter int MAX_ON_TICKS   = 30,
   parameter int COOLDOWN_TICKS = 10,
   parameter int TIMER_WIDTH    = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       earth_humidity,
   input  logic       air_humidity,
   input  logic       low_temperature,
   input  logic [2:0] water_level,
   output logic       splinker_bomb,
   output logic       drip_valve,
   output logic       supply_valve,
   output logic       sensor_error,
   output logic [2:0] state
);

   localparam logic [TIMER_WIDTH-1:0] MIN_ON   = TIMER_WIDTH'(MIN_ON_TICKS);
   localparam logic [TIMER_WIDTH-1:0] MAX_ON   = TIMER_WIDTH'(MAX_ON_TICKS);
   localparam logic [TIMER_WIDTH-1:0] COOLDOWN = TIMER_WIDTH'(COOLDOWN_TICKS);

   state_t                 state_q;
   state_t                 state_d;
   logic                   timer_clr;
   logic                   timer_en;
   logic [TIMER_WIDTH-1:0] timer;
   logic                   fault;
   logic                   critical;
   logic                   sprinkle_req;
   logic                   drip_req;
   logic                   supply_q;

   assign fault        = ~wl_legal(water_level);
   assign critical     = (water_level == WL_CRITICAL);
   assign sprinkle_req = ~earth_humidity & (~air_humidity | (~low_temperature & water_level[1]));
   assign drip_req     = ~earth_humidity & ~sprinkle_req;

   tick_timer #(
      .WIDTH (TIMER_WIDTH)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .clr   (timer_clr),
      .en    (timer_en),
      .count (timer)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_clr = 1'b0;
      timer_en  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fault) begin
               state_d = ST_FAULT;
            end else if (sprinkle_req && !critical) begin
               state_d   = ST_SPRINKLE;
               timer_clr = 1'b1;
            end else if (drip_req && !critical) begin
               state_d   = ST_DRIP;
               timer_clr = 1'b1;
            end
         end
         ST_SPRINKLE, ST_DRIP: begin
            timer_en = tick;
            // Exit tests see the pre-increment timer; a coincident tick is discarded by the clear.
            if (fault) begin
               state_d = ST_FAULT;
            end else if (critical || (earth_humidity && (timer >= MIN_ON)) || (timer == MAX_ON)) begin
               state_d   = ST_COOLDOWN;
               timer_clr = 1'b1;
            end
         end
         ST_COOLDOWN: begin
            timer_en = tick;
            if (fault) begin
               state_d = ST_FAULT;
            end else if (timer == COOLDOWN) begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (!fault) begin
               state_d   = ST_COOLDOWN;
               timer_clr = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Refill below mid level, stop at high level; a bad code always shuts the supply.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         supply_q <= 1'b0;
      end else if (fault || water_level[2]) begin
         supply_q <= 1'b0;
      end else if (!water_level[1]) begin
         supply_q <= 1'b1;
      end
   end

   assign splinker_bomb = (state_q == ST_SPRINKLE);
   assign drip_valve    = (state_q == ST_DRIP);
   assign sensor_error  = (state_q == ST_FAULT);
   assign supply_valve  = supply_q;
   assign state         = state_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench: each step queues the expected registered outputs, clocks once, then compares.
module tb_irrigation_scheduler;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SPR  = 3'd1;
   localparam logic [2:0] S_DRIP = 3'd2;
   localparam logic [2:0] S_COOL = 3'd3;
   localparam logic [2:0] S_FLT  = 3'd4;

   logic       clock = 1'b0;
   logic       reset;
   logic       tick;
   logic       earth_humidity;
   logic       air_humidity;
   logic       low_temperature;
   logic [2:0] water_level;
   logic       splinker_bomb;
   logic       drip_valve;
   logic       supply_valve;
   logic       sensor_error;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;
   logic [6:0] sb[$];

   irrigation_scheduler dut (
      .clock           (clock),
      .reset           (reset),
      .tick            (tick),
      .earth_humidity  (earth_humidity),
      .air_humidity    (air_humidity),
      .low_temperature (low_temperature),
      .water_level     (water_level),
      .splinker_bomb   (splinker_bomb),
      .drip_valve      (drip_valve),
      .supply_valve    (supply_valve),
      .sensor_error    (sensor_error),
      .state           (state)
   );

   always #5 clock = ~clock;

   // Expected output vector {state, sprinkler, drip, supply, error}.
   function automatic logic [6:0] mk(input logic [2:0] st, input logic sup);
      return {st, st == S_SPR, st == S_DRIP, sup, st == S_FLT};
   endfunction

   task automatic check(input string tag);
      logic [6:0] obs;
      logic [6:0] exp;
      obs = {state, splinker_bomb, drip_valve, supply_valve, sensor_error};
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL %s scoreboard empty observed=%b", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
         end
      end
   endtask

   task automatic step(input logic t, input logic [2:0] st, input logic sup, input string tag);
      tick = t;
      sb.push_back(mk(st, sup));
      @(posedge clock);
      #1;
      check(tag);
   endtask

   task automatic set_sensors(input logic e, input logic a, input logic lt, input logic [2:0] wl);
      earth_humidity  = e;
      air_humidity    = a;
      low_temperature = lt;
      water_level     = wl;
   endtask

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      set_sensors(1'b0, 1'b0, 1'b0, 3'b011);
      #3;
      sb.push_back(mk(S_IDLE, 1'b0));
      check("reset_state");
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Dry soil and air: sprinkler opens on the first edge, closes on the max-on limit.
      step(1'b1, S_SPR, 1'b0, "sprinkle_open");
      step(1'b0, S_SPR, 1'b0, "sprinkle_no_tick_hold");
      for (int i = 1; i <= 30; i++) step(1'b1, S_SPR, 1'b0, "sprinkle_max_on_run");
      step(1'b1, S_COOL, 1'b0, "sprinkle_max_on_exit");
      for (int i = 1; i <= 10; i++) step(1'b1, S_COOL, 1'b0, "cooldown_no_reopen");
      set_sensors(1'b0, 1'b1, 1'b1, 3'b011);
      step(1'b1, S_IDLE, 1'b0, "cooldown_exit");

      // Humid air and cold: drip; soil wets after 2 ticks but min-on holds it to 4.
      step(1'b1, S_DRIP, 1'b0, "drip_open");
      step(1'b1, S_DRIP, 1'b0, "drip_tick1");
      step(1'b1, S_DRIP, 1'b0, "drip_tick2");
      earth_humidity = 1'b1;
      step(1'b1, S_DRIP, 1'b0, "drip_min_on_t2");
      step(1'b1, S_DRIP, 1'b0, "drip_min_on_t3");
      step(1'b1, S_COOL, 1'b0, "drip_min_on_exit");
      for (int i = 1; i <= 10; i++) step(1'b1, S_COOL, 1'b0, "drip_cooldown");
      step(1'b1, S_IDLE, 1'b0, "drip_cooldown_exit");
      step(1'b1, S_IDLE, 1'b0, "idle_humid_soil");

      // Critical level while sprinkling; supply hysteresis 001 -> 000 -> 011 -> 111.
      set_sensors(1'b0, 1'b0, 1'b0, 3'b001);
      step(1'b1, S_SPR, 1'b1, "low_level_sprinkle_supply_on");
      water_level = 3'b000;
      step(1'b1, S_COOL, 1'b1, "critical_close");
      water_level = 3'b011;
      step(1'b1, S_COOL, 1'b1, "supply_hold_mid");
      water_level = 3'b111;
      step(1'b1, S_COOL, 1'b0, "supply_clear_high");
      earth_humidity = 1'b1;
      for (int i = 1; i <= 8; i++) step(1'b1, S_COOL, 1'b0, "critical_cooldown");
      step(1'b1, S_IDLE, 1'b0, "critical_cooldown_exit");

      // Illegal level code while dripping forces FAULT and shuts the refill.
      set_sensors(1'b0, 1'b1, 1'b1, 3'b001);
      step(1'b1, S_DRIP, 1'b1, "drip_low_level");
      water_level = 3'b101;
      step(1'b1, S_FLT, 1'b0, "fault_enter");
      step(1'b1, S_FLT, 1'b0, "fault_hold");
      water_level = 3'b011;
      step(1'b1, S_COOL, 1'b0, "fault_recover");
      earth_humidity = 1'b1;
      for (int i = 1; i <= 10; i++) step(1'b1, S_COOL, 1'b0, "fault_cooldown");
      step(1'b1, S_IDLE, 1'b0, "fault_cooldown_exit");

      // Async reset mid-sprinkle at timer=7, then a full max-on run proves the timer restarted.
      set_sensors(1'b0, 1'b0, 1'b0, 3'b011);
      step(1'b1, S_SPR, 1'b0, "resprinkle_open");
      for (int i = 1; i <= 7; i++) step(1'b1, S_SPR, 1'b0, "resprinkle_to_7");
      #2;
      reset = 1'b1;
      #1;
      sb.push_back(mk(S_IDLE, 1'b0));
      check("async_reset_close");
      @(posedge clock);
      #1;
      reset = 1'b0;
      step(1'b1, S_SPR, 1'b0, "post_reset_open");
      for (int i = 1; i <= 30; i++) step(1'b1, S_SPR, 1'b0, "post_reset_full_run");
      step(1'b1, S_COOL, 1'b0, "post_reset_max_exit");

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
